// File: rtl/capture_rd_ctrl.sv
// rtl/capture_rd_ctrl.sv - pipelined register-bus read port for the two-bank circular capture buffer
// Optional auto-increment read pointer: define CAPTURE_RD_AUTO_INC_EN.
module capture_rd_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int RAM_RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    capture_enable,
    input  logic [ADDR_WIDTH-1:0]   read_start_addr,
    input  logic [ADDR_WIDTH-1:0]   capture_max_addr,
    input  logic                    dbg_in_rd_en,
    input  logic                    capture_rd_en,
    input  logic [ADDR_WIDTH-1:0]   capture_rd_addr,
    input  logic                    capture_rd_addr_ld,
    output logic [DATA_WIDTH-1:0]   capture_rd_data,
    output logic                    capture_rd_data_vld,
    output logic                    capture_rd_err,
    output logic                    ram0_rd_en,
    output logic [ADDR_WIDTH-2:0]   ram0_raddr,
    input  logic [DATA_WIDTH/2-1:0] ram0_rdata,
    output logic                    ram1_rd_en,
    output logic [ADDR_WIDTH-2:0]   ram1_raddr,
    input  logic [DATA_WIDTH/2-1:0] ram1_rdata
);

    localparam int AW = ADDR_WIDTH;

    // Logical offset of the current request
    logic [AW-1:0] w_l;
    // Logical offset of the second sample, wrapped at the end of the buffer
    logic [AW-1:0] w_l1;
    // Unwrapped physical addresses computed one bit wider to hold the carry
    logic [AW:0]   w_sum0;
    logic [AW:0]   w_sum1;
    logic [AW:0]   w_max_ext;
    logic [AW:0]   w_depth;
    logic [AW-1:0] w_p0;
    logic [AW-1:0] w_p1;
    logic          w_err;
    logic          w_swap;
    logic          w_ram_en;
    logic [AW-2:0] w_idx_even;
    logic [AW-2:0] w_idx_odd;

    // Per-request pipeline state, index i holds the request accepted i cycles ago
    logic [RAM_RD_LAT:0] r_vld_pipe;
    logic [RAM_RD_LAT:0] r_err_pipe;
    logic [RAM_RD_LAT:0] r_swap_pipe;

    // Assembled word once the RAM data has arrived
    logic                  r_cap_vld;
    logic                  r_cap_err;
    logic [DATA_WIDTH-1:0] r_cap_data;

`ifdef CAPTURE_RD_AUTO_INC_EN
    logic [AW-1:0] r_ptr;
    logic [AW:0]   w_ptr_nxt;

    // Pointer-driven offset unless the request explicitly loads a new one
    always_comb begin
        w_l       = capture_rd_addr_ld ? capture_rd_addr : r_ptr;
        w_ptr_nxt = {1'b0, w_l} + {{AW{1'b0}}, 1'b0} + (AW+1)'(2);
    end

    // Advance the read pointer by one word (two samples) on every accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (capture_rd_en) begin
            if (dbg_in_rd_en)
                r_ptr <= w_ptr_nxt[AW-1:0];
            else if (w_ptr_nxt > w_max_ext)
                r_ptr <= '0;
            else
                r_ptr <= w_ptr_nxt[AW-1:0];
        end
    end
`else
    logic w_unused_ld;

    // Offset comes straight from the bus; the load qualifier has no meaning here
    always_comb begin
        w_l         = capture_rd_addr;
        w_unused_ld = capture_rd_addr_ld;
    end
`endif

    // Unwrap the logical offsets, validate the request and steer the banks
    always_comb begin
        w_max_ext = {1'b0, capture_max_addr};
        w_depth   = w_max_ext + (AW+1)'(1);
        w_l1      = (w_l == capture_max_addr) ? '0 : w_l + 1'b1;
        w_sum0    = {1'b0, read_start_addr} + {1'b0, w_l};
        w_sum1    = {1'b0, read_start_addr} + {1'b0, w_l1};
        if (w_sum0 > w_max_ext)
            w_sum0 = w_sum0 - w_depth;
        if (w_sum1 > w_max_ext)
            w_sum1 = w_sum1 - w_depth;

        if (dbg_in_rd_en) begin
            w_p0  = w_l;
            w_p1  = w_l + 1'b1;
            w_err = 1'b0;
        end else begin
            w_p0  = w_sum0[AW-1:0];
            w_p1  = w_sum1[AW-1:0];
            w_err = (w_l > capture_max_addr) | ~capture_max_addr[0] | capture_enable;
        end

        // With an even depth p0 and p1 differ in parity, so each bank gets exactly one
        w_swap     = w_p0[0];
        w_idx_even = w_swap ? w_p1[AW-1:1] : w_p0[AW-1:1];
        w_idx_odd  = w_swap ? w_p0[AW-1:1] : w_p1[AW-1:1];
        w_ram_en   = capture_rd_en & ~w_err;
    end

    // Issue the bank reads one cycle after acceptance; rejected requests skip the RAMs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram0_rd_en <= 1'b0;
            ram1_rd_en <= 1'b0;
            ram0_raddr <= '0;
            ram1_raddr <= '0;
        end else begin
            ram0_rd_en <= w_ram_en;
            ram1_rd_en <= w_ram_en;
            if (w_ram_en) begin
                ram0_raddr <= w_idx_even;
                ram1_raddr <= w_idx_odd;
            end
        end
    end

    // Carry valid/err/swap alongside the RAM access so errors stay in order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe  <= '0;
            r_err_pipe  <= '0;
            r_swap_pipe <= '0;
        end else begin
            r_vld_pipe  <= {r_vld_pipe[RAM_RD_LAT-1:0],  capture_rd_en};
            r_err_pipe  <= {r_err_pipe[RAM_RD_LAT-1:0],  w_err};
            r_swap_pipe <= {r_swap_pipe[RAM_RD_LAT-1:0], w_swap};
        end
    end

    // Sample the bank data when it becomes valid and put the lower sample in the low half
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_vld  <= 1'b0;
            r_cap_err  <= 1'b0;
            r_cap_data <= '0;
        end else begin
            r_cap_vld <= r_vld_pipe[RAM_RD_LAT];
            r_cap_err <= r_err_pipe[RAM_RD_LAT];
            if (r_vld_pipe[RAM_RD_LAT]) begin
                if (r_err_pipe[RAM_RD_LAT])
                    r_cap_data <= '0;
                else if (r_swap_pipe[RAM_RD_LAT])
                    r_cap_data <= {ram0_rdata, ram1_rdata};
                else
                    r_cap_data <= {ram1_rdata, ram0_rdata};
            end
        end
    end

    // Register the response; data holds between responses, err only qualifies a response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture_rd_data     <= '0;
            capture_rd_data_vld <= 1'b0;
            capture_rd_err      <= 1'b0;
        end else begin
            capture_rd_data_vld <= r_cap_vld;
            capture_rd_err      <= r_cap_vld & r_cap_err;
            if (r_cap_vld)
                capture_rd_data <= r_cap_data;
        end
    end

endmodule

// File: tb/tb_capture_rd_ctrl.sv
// tb/tb_capture_rd_ctrl.sv - scoreboard bench for capture_rd_ctrl at RAM latency 1 and 3
module tb_capture_rd_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        capture_enable;
    logic [13:0] start;
    logic [13:0] maxa;
    logic        dbg;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic        ld;

    logic [31:0] data_a, data_b;
    logic        vld_a, vld_b, err_a, err_b;
    logic        r0en_a, r1en_a, r0en_b, r1en_b;
    logic [12:0] r0addr_a, r1addr_a, r0addr_b, r1addr_b;
    logic [15:0] r0data_a, r1data_a;
    logic [15:0] b0 [3];
    logic [15:0] b1 [3];

    capture_rd_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .RAM_RD_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .capture_enable(capture_enable),
        .read_start_addr(start), .capture_max_addr(maxa), .dbg_in_rd_en(dbg),
        .capture_rd_en(rd_en), .capture_rd_addr(rd_addr), .capture_rd_addr_ld(ld),
        .capture_rd_data(data_a), .capture_rd_data_vld(vld_a), .capture_rd_err(err_a),
        .ram0_rd_en(r0en_a), .ram0_raddr(r0addr_a), .ram0_rdata(r0data_a),
        .ram1_rd_en(r1en_a), .ram1_raddr(r1addr_a), .ram1_rdata(r1data_a));

    capture_rd_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .RAM_RD_LAT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .capture_enable(capture_enable),
        .read_start_addr(start), .capture_max_addr(maxa), .dbg_in_rd_en(dbg),
        .capture_rd_en(rd_en), .capture_rd_addr(rd_addr), .capture_rd_addr_ld(ld),
        .capture_rd_data(data_b), .capture_rd_data_vld(vld_b), .capture_rd_err(err_b),
        .ram0_rd_en(r0en_b), .ram0_raddr(r0addr_b), .ram0_rdata(b0[2]),
        .ram1_rd_en(r1en_b), .ram1_raddr(r1addr_b), .ram1_rdata(b1[2]));

    function automatic logic [15:0] samp(logic [13:0] a);
        return {2'b11, a} ^ 16'h5A5A;
    endfunction

    function automatic logic [13:0] phys(logic [13:0] s, logic [13:0] m, logic [13:0] l);
        return 14'((int'(s) + int'(l)) % (int'(m) + 1));
    endfunction

    // RAM models: latency 1 for A, latency 3 for B
    always @(posedge clk) begin
        if (r0en_a) r0data_a <= samp({r0addr_a, 1'b0});
        if (r1en_a) r1data_a <= samp({r1addr_a, 1'b1});
        if (r0en_b) b0[0] <= samp({r0addr_b, 1'b0});
        if (r1en_b) b1[0] <= samp({r1addr_b, 1'b1});
        b0[1] <= b0[0]; b0[2] <= b0[1];
        b1[1] <= b1[0]; b1[2] <= b1[1];
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q [2][$];
    logic [31:0] last [2];
    logic        vld_w [2];
    logic        err_w [2];
    logic [31:0] dat_w [2];
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    int          rdcnt = 0;
    int          exp_rdcnt = 0;
    bit          mon_on = 1'b0;

    assign vld_w[0] = vld_a;  assign vld_w[1] = vld_b;
    assign err_w[0] = err_a;  assign err_w[1] = err_b;
    assign dat_w[0] = data_a; assign dat_w[1] = data_b;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (r0en_a) rdcnt <= rdcnt + 1;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: pop the scoreboard on every vld, check hold/err/latency otherwise
    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 2; k++) begin
                string t;
                exp_t  e;
                t = (k == 0) ? "lat1" : "lat3";
                if (vld_w[k]) begin
                    if (q[k].size() == 0) begin
                        chk({t, "_unexpected_vld"}, 32'd1, 32'd0);
                    end else begin
                        e = q[k].pop_front();
                        chk({t, "_data"}, dat_w[k], e.data);
                        chk({t, "_err"}, 32'(err_w[k]), 32'(e.err));
                        chk({t, "_latency"}, 32'(cyc), 32'(e.due));
                        last[k] = e.data;
                    end
                end else begin
                    chk({t, "_err_idle"}, 32'(err_w[k]), 32'd0);
                    chk({t, "_data_hold"}, dat_w[k], last[k]);
                    if (q[k].size() > 0 && q[k][0].due < cyc) begin
                        chk({t, "_missing_vld"}, 32'(cyc), 32'(q[k][0].due));
                        void'(q[k].pop_front());
                    end
                end
            end
            chk("ram_en_pair", 32'(r1en_a), 32'(r0en_a));
        end
    end

    // Drive one request at a negedge, record expectations, check the bank access one cycle later
    task automatic issue(logic [13:0] l, logic [13:0] p0, logic [13:0] p1, logic err);
        exp_t e;
        rd_addr = l;
        rd_en   = 1'b1;
        e.err   = err;
        e.data  = err ? 32'd0 : {samp(p1), samp(p0)};
        e.due   = cyc + 4;
        q[0].push_back(e);
        e.due   = cyc + 6;
        q[1].push_back(e);
        if (!err) exp_rdcnt++;
        @(negedge clk);
        chk("ram0_rd_en", 32'(r0en_a), 32'(!err));
        chk("ram0_rd_en_lat3", 32'(r0en_b), 32'(!err));
        if (!err) begin
            chk("ram0_raddr", 32'(r0addr_a), 32'(p0[0] ? p1[13:1] : p0[13:1]));
            chk("ram1_raddr", 32'(r1addr_a), 32'(p0[0] ? p0[13:1] : p1[13:1]));
        end
    endtask

    task automatic issue_n(logic [13:0] l);
        logic [13:0] l1;
        logic        e;
        l1 = (l == maxa) ? 14'd0 : l + 14'd1;
        e  = !dbg && ((l > maxa) || !maxa[0] || capture_enable);
        issue(l, phys(start, maxa, l), phys(start, maxa, l1), e);
    endtask

    task automatic idle(int n);
        rd_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; capture_enable = 1'b0; start = '0; maxa = 14'h3FFF;
        dbg = 1'b0; rd_en = 1'b0; rd_addr = '0; ld = 1'b0;
        last[0] = '0; last[1] = '0;
        repeat (3) @(negedge clk);
        chk("rst_vld", 32'(vld_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_data", data_a, 32'd0);
        chk("rst_ram_en", 32'(r0en_a | r1en_a | r0en_b), 32'd0);
        chk("rst_raddr", 32'({r0addr_a, r1addr_a}), 32'd0);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);

        // Straight read at the start of a full-size buffer
        maxa = 14'h3FFF; start = 14'h0100;
        issue(14'h0000, 14'h0100, 14'h0101, 1'b0);
        chk("tp1_ram0_idx", 32'(r0addr_a), 32'h080);
        idle(8);

        // Physical wrap between the two samples forces a lane swap
        maxa = 14'h00FF; start = 14'h00F1;
        issue(14'h000E, 14'h00FF, 14'h0000, 1'b0);
        chk("tp2_ram0_idx", 32'(r0addr_a), 32'h000);
        chk("tp2_ram1_idx", 32'(r1addr_a), 32'h07F);
        idle(8);

        // Logical wrap of the second sample
        start = 14'h0010;
        issue(14'h00FF, 14'h000F, 14'h0010, 1'b0);
        idle(8);

        // Three back-to-back rejections
        start = 14'h0000;
        issue(14'h0100, 14'h0, 14'h0, 1'b1);
        maxa = 14'h00FE;
        issue(14'h0010, 14'h0, 14'h0, 1'b1);
        maxa = 14'h00FF; capture_enable = 1'b1;
        issue(14'h0010, 14'h0, 14'h0, 1'b1);
        idle(8);

        // Same conditions in raw mode are served
        dbg = 1'b1; capture_enable = 1'b0;
        issue(14'h0100, 14'h0100, 14'h0101, 1'b0);
        maxa = 14'h00FE;
        issue(14'h0100, 14'h0100, 14'h0101, 1'b0);
        capture_enable = 1'b1;
        issue(14'h3FFF, 14'h3FFF, 14'h0000, 1'b0);
        idle(8);
        dbg = 1'b0; capture_enable = 1'b0;

        // Eight back-to-back requests across the physical wrap
        maxa = 14'h00FF; start = 14'h00F8;
        for (int i = 0; i < 8; i++) issue_n(14'(i));
        idle(10);

        // Reset in the middle of a burst drops everything in flight
        for (int i = 0; i < 4; i++) issue_n(14'(i + 16));
        rd_en = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q[0].delete(); q[1].delete();
        last[0] = '0; last[1] = '0;
        repeat (2) @(negedge clk);
        chk("mid_rst_data", data_b, 32'd0);
        rst_n = 1'b1;
        idle(10);

`ifdef CAPTURE_RD_AUTO_INC_EN
        // Auto-increment pointer with wrap at a small depth
        maxa = 14'h0013; start = 14'h0000;
        ld = 1'b1;
        issue(14'h0010, 14'h0010, 14'h0011, 1'b0);
        ld = 1'b0;
        issue(14'h0000, 14'h0012, 14'h0013, 1'b0);
        issue(14'h0000, 14'h0000, 14'h0001, 1'b0);
        issue(14'h0000, 14'h0002, 14'h0003, 1'b0);
        idle(10);
`endif

        idle(4);
        chk("drained_lat1", 32'(q[0].size()), 32'd0);
        chk("drained_lat3", 32'(q[1].size()), 32'd0);
        chk("ram_read_count", 32'(rdcnt), 32'(exp_rdcnt));
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/capture_rd_ctrl.md
Name: capture_rd_ctrl

Overview:
- Read-side stage downstream of the capture write controller. Serves register-bus reads of the circular capture buffer held in two half-width RAMs.
- Even samples live in ram0 and odd samples in ram1. The RAM index of a sample is sample_addr[ADDR_WIDTH-1:1].
- Each read unwraps a logical offset against read_start_addr and capture_max_addr. It fetches two consecutive samples in parallel and returns them as one DATA_WIDTH word.
- The block is pipelined: one request per cycle is accepted, and results return in request order.

Parameters:
DATA_WIDTH, 32, returned word width; each RAM is DATA_WIDTH/2 wide (one sample)
ADDR_WIDTH, 14, sample address width; each RAM address is ADDR_WIDTH-1 bits
RAM_RD_LAT, 1, RAM read latency in cycles from rd_en to rdata valid (legal values 1..3)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
capture_enable  input  1  capture in progress; normal reads are rejected while high
read_start_addr  input  ADDR_WIDTH  physical address of the oldest sample (logical offset 0)
capture_max_addr  input  ADDR_WIDTH  last physical sample address; depth = max+1
dbg_in_rd_en  input  1  raw mode: capture_rd_addr is used as a physical address, no unwrap or range check
capture_rd_en  input  1  read request strobe, one request per cycle
capture_rd_addr  input  ADDR_WIDTH  logical offset (physical address in raw mode)
capture_rd_addr_ld  input  1  auto-increment pointer load qualifier (used only with the macro)
capture_rd_data  output  DATA_WIDTH  {sample[L+1], sample[L]}
capture_rd_data_vld  output  1  one-cycle response strobe
capture_rd_err  output  1  qualifies a response as rejected; valid only with capture_rd_data_vld
ram0_rd_en  output  1  even-bank read enable
ram0_raddr  output  ADDR_WIDTH-1  even-bank index
ram0_rdata  input  DATA_WIDTH/2  even-bank data
ram1_rd_en  output  1  odd-bank read enable
ram1_raddr  output  ADDR_WIDTH-1  odd-bank index
ram1_rdata  input  DATA_WIDTH/2  odd-bank data

Behaviour:
- Reset: all outputs are 0, pipeline valids are cleared, and the auto-increment pointer is 0.
- Asserting rst_n low mid-operation drops all in-flight requests; no response is issued for them.
- Request accepted at cycle T (capture_rd_en high at clk edge).
- Address calculation is done in ADDR_WIDTH+1 bits:
  - p0 = read_start_addr + L; if p0 > capture_max_addr then p0 -= capture_max_addr+1.
  - L1 = (L == capture_max_addr) ? 0 : L+1; p1 is computed from L1 with the same rule.
- Raw mode (dbg_in_rd_en=1): p0 = capture_rd_addr and p1 = capture_rd_addr+1 mod 2^ADDR_WIDTH. capture_enable is ignored.
- Rejection conditions (error response, no RAM access, capture_rd_data=0, capture_rd_err=1):
  - L > capture_max_addr;
  - capture_max_addr[0]==0 (odd depth);
  - capture_enable=1 in normal mode.
  - All three checks are skipped in raw mode.
- Lane steering:
  - Since depth is even, p0 and p1 always have opposite parity.
  - Even address to ram0 index, odd address to ram1 index.
  - swap = p0[0] is carried down the pipeline with the request.
- T+1: ram0_rd_en and ram1_rd_en are high for one cycle, with registered raddr.
- T+1+RAM_RD_LAT: RAM data is sampled.
- Output word: swap=0 gives {ram1_rdata, ram0_rdata}; swap=1 gives {ram0_rdata, ram1_rdata}.
- T+2+RAM_RD_LAT: capture_rd_data and capture_rd_data_vld are registered. Fixed latency is RAM_RD_LAT+2 cycles for both good and error responses.
- Error responses travel the same valid/err pipeline so that ordering is preserved.
- capture_rd_data holds its last value when vld=0. capture_rd_err is 0 whenever vld=0.
- There is no backpressure; the consumer must accept vld every cycle.
- Changes to read_start_addr or capture_max_addr are sampled at T only; in-flight requests are unaffected.

Optional Feature:
CAPTURE_RD_AUTO_INC_EN:
- With the macro:
  - capture_rd_en with capture_rd_addr_ld=1 uses capture_rd_addr and loads ptr = capture_rd_addr+2.
  - capture_rd_en with ld=0 uses L = ptr, then ptr += 2, wrapping to 0 past capture_max_addr (raw mode: modulo 2^ADDR_WIDTH).
  - The pointer advances on error responses too.
- Without the macro: capture_rd_addr_ld is ignored, L is always capture_rd_addr, and no pointer register exists.

Test Plan:
- max=0x3FFF, start=0x0100, L=0 -> ram0 idx 0x080 and ram1 idx 0x080; data={s[0x101],s[0x100]}; vld at T+3 (RAM_RD_LAT=1).
- max=0x00FF, start=0x00F1, L=0x0E -> p0=0xFF, p1=0x00; swap=1; data={s[0x00],s[0xFF]}.
- L=0x00FF with max=0x00FF, start=0x0010 -> L1 wraps to 0: p0=0x0F, p1=0x10.
- L=0x0100 with max=0x00FF; then max=0x00FE; then capture_enable=1 -> three back-to-back err responses with data 0 and no RAM rd_en. Repeating with dbg_in_rd_en=1 gives good data.
- 8 back-to-back requests, L=0..7, with RAM_RD_LAT=1 and 3 -> 8 consecutive vld in order. Assert rst_n low mid-burst -> no further vld.
- Macro on: ld at L=0x10, then 3 reads without ld -> L=0x10, 0x12, 0x14, 0x16. With max=0x13, the read after L=0x12 uses L=0x00.
